// File: rtl/xmit_sched_pkg.sv
// Shared types and default constants for the transmit scheduler.
package xmit_pkg;

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        DISC,
        GAP
    } state_e;

    localparam int XMIT_LEN_W        = 12;
    localparam int XMIT_MAX_LEN      = 1518;
    localparam int XMIT_IFG_CYCLES   = 12;
    localparam int XMIT_HI_BURST_MAX = 4;

endpackage

// File: rtl/xmit_sched_if.sv
// Control-FIFO and transmitter bundle of the transmit scheduler.
interface xmit_sched_if #(
    parameter int LEN_W = 12
);

    logic             hi_avail;
    logic [LEN_W-1:0] hi_len;
    logic             lo_avail;
    logic [LEN_W-1:0] lo_len;
    logic             tx_ready;
    logic             pop_hi;
    logic             pop_lo;
    logic             q_sel;
    logic             data_rd;
    logic             tx_valid;
    logic             tx_sof;
    logic             tx_eof;
    logic             discard_en;
    logic             busy;

    modport master (
        input  hi_avail,
        input  hi_len,
        input  lo_avail,
        input  lo_len,
        input  tx_ready,
        output pop_hi,
        output pop_lo,
        output q_sel,
        output data_rd,
        output tx_valid,
        output tx_sof,
        output tx_eof,
        output discard_en,
        output busy
    );

    modport slave (
        output hi_avail,
        output hi_len,
        output lo_avail,
        output lo_len,
        output tx_ready,
        input  pop_hi,
        input  pop_lo,
        input  q_sel,
        input  data_rd,
        input  tx_valid,
        input  tx_sof,
        input  tx_eof,
        input  discard_en,
        input  busy
    );

endinterface

// File: rtl/xmit_sched_arb.sv
// Queue grant selection; XMIT_SCHED_STARVE_GUARD_EN adds a high-priority
// streak limit so the low queue cannot be starved.
module xmit_sched_arb
    import xmit_pkg::*;
`ifdef XMIT_SCHED_STARVE_GUARD_EN
#(
    parameter int HI_BURST_MAX = XMIT_HI_BURST_MAX
)
`endif
(
`ifdef XMIT_SCHED_STARVE_GUARD_EN
    input  logic clk_sys,
    input  logic reset_n,
    input  logic grant_en,
`endif
    input  logic hi_avail,
    input  logic lo_avail,
    output logic gnt_hi,
    output logic gnt_lo
);

`ifdef XMIT_SCHED_STARVE_GUARD_EN
    localparam int SW = $clog2(HI_BURST_MAX + 1);
    localparam logic [SW-1:0] CAP = SW'(HI_BURST_MAX);

    logic [SW-1:0] streak_q;
    logic          force_lo;

    assign force_lo = lo_avail && (streak_q == CAP);
    assign gnt_hi   = hi_avail && !force_lo;

    // Streak only grows while low traffic is actually being held off.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            streak_q <= '0;
        end else if (grant_en) begin
            if (gnt_hi && lo_avail) begin
                if (streak_q != CAP) begin
                    streak_q <= streak_q + SW'(1);
                end
            end else begin
                streak_q <= '0;
            end
        end
    end
`else
    assign gnt_hi = hi_avail;
`endif

    assign gnt_lo = lo_avail && !gnt_hi;

endmodule

// File: rtl/xmit_sched.sv
// Two-queue frame transmit scheduler: grant, transfer or discard, then
// inter-frame gap. Optional starvation guard via XMIT_SCHED_STARVE_GUARD_EN.
module xmit_sched
    import xmit_pkg::*;
#(
    parameter int LEN_W        = XMIT_LEN_W,
    parameter int MAX_LEN      = XMIT_MAX_LEN,
    parameter int IFG_CYCLES   = XMIT_IFG_CYCLES,
    parameter int HI_BURST_MAX = XMIT_HI_BURST_MAX
) (
    input logic          clk_sys,
    input logic          reset_n,
    xmit_sched_if.master bus
);

    localparam logic [LEN_W-1:0] MAX_LEN_V = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] GAP_LAST  = LEN_W'(IFG_CYCLES - 1);

    if (HI_BURST_MAX < 1 || IFG_CYCLES < 1) begin : g_param_check
        $error("xmit_sched: HI_BURST_MAX and IFG_CYCLES must be >= 1");
    end

    state_e           state_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] cnt_q;
    logic             q_sel_q;

    logic             grant_en;
    logic             gnt_hi;
    logic             gnt_lo;
    logic [LEN_W-1:0] gnt_len;
    logic             gnt_bad;
    logic             last;
    logic             xfer_acc;
    logic             disc_st;

    // Reset gates the grant so no pop leaks out while held in reset.
    always_comb begin
        grant_en = reset_n && (state_q == IDLE)
                 && (bus.hi_avail || bus.lo_avail);
        gnt_len  = gnt_hi ? bus.hi_len : bus.lo_len;
        gnt_bad  = (gnt_len == '0) || (gnt_len > MAX_LEN_V);
        last     = (cnt_q == len_q - LEN_W'(1));
        xfer_acc = (state_q == XFER) && bus.tx_ready;
        disc_st  = (state_q == DISC);
    end

    xmit_sched_arb
`ifdef XMIT_SCHED_STARVE_GUARD_EN
    #(
        .HI_BURST_MAX(HI_BURST_MAX)
    )
`endif
    u_arb (
`ifdef XMIT_SCHED_STARVE_GUARD_EN
        .clk_sys  (clk_sys),
        .reset_n  (reset_n),
        .grant_en (grant_en),
`endif
        .hi_avail (bus.hi_avail),
        .lo_avail (bus.lo_avail),
        .gnt_hi   (gnt_hi),
        .gnt_lo   (gnt_lo)
    );

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            q_sel_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (grant_en) begin
                        len_q   <= gnt_len;
                        q_sel_q <= gnt_hi;
                        cnt_q   <= '0;
                        state_q <= gnt_bad ? DISC : XFER;
                    end
                end
                XFER: begin
                    if (bus.tx_ready) begin
                        if (last) begin
                            cnt_q   <= '0;
                            state_q <= GAP;
                        end else begin
                            cnt_q <= cnt_q + LEN_W'(1);
                        end
                    end
                end
                DISC: begin
                    if (len_q == '0 || last) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + LEN_W'(1);
                    end
                end
                GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + LEN_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.pop_hi     = grant_en && gnt_hi;
    assign bus.pop_lo     = grant_en && gnt_lo;
    assign bus.q_sel      = q_sel_q;
    assign bus.data_rd    = xfer_acc || (disc_st && len_q != '0);
    assign bus.tx_valid   = xfer_acc;
    assign bus.tx_sof     = xfer_acc && (cnt_q == '0);
    assign bus.tx_eof     = xfer_acc && last;
    assign bus.discard_en = disc_st && (len_q == '0 || last);
    assign bus.busy       = (state_q != IDLE);

endmodule

// File: doc/xmit_sched.md
XMIT_SCHED -- requirements
Module: xmit_sched

Interface
REQ-001 SHALL have parameter LEN_W, default 12: width of frame length fields.
REQ-002 SHALL have parameter MAX_LEN, default 1518: largest transmittable frame in bytes.
REQ-003 SHALL have parameter IFG_CYCLES, default 12: inter-frame gap in clk_sys cycles.
REQ-004 SHALL have parameter HI_BURST_MAX, default 4: consecutive high-priority grants allowed while low waits.
REQ-005 SHALL have ports:
  clk_sys  in  1  sole clock, rising edge.
  reset_n  in  1  asynchronous, active-low reset.
  hi_avail  in  1  high-priority control-block FIFO non-empty.
  hi_len  in  LEN_W  head-of-queue frame length, bytes.
  lo_avail  in  1  low-priority control-block FIFO non-empty.
  lo_len  in  LEN_W  head-of-queue frame length, bytes.
  tx_ready  in  1  PHY-side transmitter accepts a byte this cycle.
  pop_hi  out  1  one-cycle pop of high control FIFO.
  pop_lo  out  1  one-cycle pop of low control FIFO.
  q_sel  out  1  data mux select: 1 = high queue.
  data_rd  out  1  read one byte from selected data FIFO.
  tx_valid  out  1  byte presented to transmitter.
  tx_sof  out  1  first byte of frame, qualifies tx_valid.
  tx_eof  out  1  last byte of frame, qualifies tx_valid.
  discard_en  out  1  one-cycle pulse: current frame dropped.
  busy  out  1  state is not IDLE.

Function
REQ-006 SHALL implement states IDLE, XFER, DISC, GAP.
REQ-007 In IDLE, with hi_avail or lo_avail, SHALL grant one queue, pulse its pop, latch its length and q_sel; next cycle enters XFER, or DISC if length is 0 or > MAX_LEN.
REQ-008 Grant SHALL be high queue when hi_avail, otherwise low queue, subject to REQ-016.
REQ-009 In XFER, data_rd and tx_valid SHALL equal tx_ready; byte counter SHALL advance only when tx_ready; tx_ready low stalls with no byte lost.
REQ-010 tx_sof SHALL assert with the first accepted byte, tx_eof with byte number equal to latched length; length 1 asserts both together.
REQ-011 After tx_eof, SHALL enter GAP for exactly IFG_CYCLES cycles, then IDLE; no grant during GAP.
REQ-012 In DISC, data_rd SHALL assert every cycle regardless of tx_ready, tx_valid SHALL stay 0, for latched-length cycles; discard_en pulses on the last read; then IDLE without gap.
REQ-013 Length 0 SHALL pulse discard_en in the single DISC cycle with no data_rd, then IDLE.
REQ-014 Byte counter SHALL be LEN_W bits and SHALL not wrap within a frame.
REQ-015 Control-input changes outside IDLE SHALL be ignored.

Reset
REQ-016 (see Configuration).
REQ-017 reset_n low SHALL immediately force IDLE, clear counters and streak, drive every output 0, including mid-frame; no eof or discard is emitted for the aborted frame.

Configuration
REQ-018 Macro XMIT_SCHED_STARVE_GUARD_EN defined: a saturating streak counter increments on each high grant made while lo_avail, clears on a low grant or on a high grant with lo_avail low; when streak equals HI_BURST_MAX and lo_avail, the low queue SHALL be granted.
REQ-019 Macro undefined: strict priority, no streak counter is instantiated.

Structure
REQ-020 Shared package xmit_pkg SHALL hold the state enumeration and default constants for MAX_LEN, IFG_CYCLES, HI_BURST_MAX.
REQ-021 Sub-module xmit_sched_arb SHALL contain grant selection and the streak counter; FSM and counters stay in xmit_sched.

Verification
REQ-022 hi_len=512, tx_ready=1: pop_hi one cycle; 512 consecutive data_rd; tx_sof on byte 1, tx_eof on byte 512; 12 GAP cycles; busy then 0.
REQ-023 Both queues permanently available, len=64: guard defined -> grant order H,H,H,H,L,H,H,H,H,L; undefined -> all H.
REQ-024 hi_len=2000: 2000 data_rd, tx_valid never 1, discard_en on last read, IDLE next cycle; hi_len=0: discard_en, zero data_rd.
REQ-025 tx_ready low for 10 cycles at byte 100 of 512: data_rd/tx_valid low for those 10 cycles; tx_eof still exactly on byte 512.
REQ-026 reset_n low at byte 200: all outputs 0 same cycle; after release, new grant starts clean with tx_sof on next frame's byte 1.
